// File: rtl/fft_conv_tile_scheduler_pkg.sv
// Shared types for the frequency-domain MAC tile scheduler and its tag pipe.
package fft_conv_tile_scheduler_pkg;

    localparam int TAG_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_IDX_W-1:0] oc;
        logic [TAG_IDX_W-1:0] tile;
    } mac_tag_t;

endpackage

// File: rtl/fft_conv_tile_scheduler_tag_pipe.sv
// Fixed-latency delay line carrying MAC tags alongside memory read data.
module fft_sched_tag_pipe
    import fft_conv_tile_scheduler_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  mac_tag_t tag_in,
    output mac_tag_t tag_out
);

    mac_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/fft_conv_tile_scheduler.sv
// Walks (oc, tile, ic) issuing image/kernel block reads and tagging the MAC beats.
module fft_conv_tile_scheduler
    import fft_conv_tile_scheduler_pkg::*;
#(
    parameter int NUM_TILES             = 16,
    parameter int NUM_IN_CH             = 8,
    parameter int NUM_OUT_CH            = 8,
    parameter int IMAGE_MEM_DEPTH_BITS  = 13,
    parameter int KERNEL_MEM_DEPTH_BITS = 9,
    parameter int MEM_RD_LATENCY        = 1,
    localparam int OC_W = (NUM_OUT_CH > 1) ? $clog2(NUM_OUT_CH) : 1,
    localparam int T_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             stall,
    output logic                             busy,
    output logic                             done,
    output logic [IMAGE_MEM_DEPTH_BITS-1:0]  img_rd_addr,
    output logic [KERNEL_MEM_DEPTH_BITS-1:0] ker_rd_addr,
    output logic                             mac_valid,
    output logic                             mac_first,
    output logic                             mac_last,
    output logic [OC_W-1:0]                  out_ch,
    output logic [T_W-1:0]                   out_tile
);

    localparam int IC_W  = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1;
    localparam int LAT_W = (MEM_RD_LATENCY > 1) ? $clog2(MEM_RD_LATENCY) : 1;
    localparam int IW    = IMAGE_MEM_DEPTH_BITS;
    localparam int KW    = KERNEL_MEM_DEPTH_BITS;

    if (NUM_TILES * NUM_IN_CH > 2 ** IMAGE_MEM_DEPTH_BITS) begin : g_img_chk
        $fatal(1, "image read address too narrow for NUM_TILES*NUM_IN_CH");
    end
    if (NUM_OUT_CH * NUM_IN_CH > 2 ** KERNEL_MEM_DEPTH_BITS) begin : g_ker_chk
        $fatal(1, "kernel read address too narrow for NUM_OUT_CH*NUM_IN_CH");
    end
    if (MEM_RD_LATENCY < 1 || OC_W > TAG_IDX_W || T_W > TAG_IDX_W) begin : g_tag_chk
        $fatal(1, "unsupported latency or tag width");
    end

    sched_state_t     state, state_next;
    logic [OC_W-1:0]  oc, oc_n;
    logic [T_W-1:0]   tile, tile_n;
    logic [IC_W-1:0]  ic, ic_n;
    logic [LAT_W-1:0] drain_cnt;
    logic             fire, ic_wrap, tile_wrap, oc_wrap, last_issue;
    mac_tag_t         tag_in, tag_out;
    logic             unused_tag;

    // the counters always name the read currently presented on the address ports
    assign fire       = (state == RUN) && !stall;
    assign ic_wrap    = (ic == IC_W'(NUM_IN_CH - 1));
    assign tile_wrap  = (tile == T_W'(NUM_TILES - 1));
    assign oc_wrap    = (oc == OC_W'(NUM_OUT_CH - 1));
    assign last_issue = fire && ic_wrap && tile_wrap && oc_wrap;

    always_comb begin
        ic_n   = ic;
        tile_n = tile;
        oc_n   = oc;
        if (state == IDLE) begin
            ic_n   = '0;
            tile_n = '0;
            oc_n   = '0;
        end else if (fire) begin
            ic_n = ic_wrap ? '0 : ic + IC_W'(1);
            if (ic_wrap) begin
                tile_n = tile_wrap ? '0 : tile + T_W'(1);
                if (tile_wrap) begin
                    oc_n = oc_wrap ? '0 : oc + OC_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (drain_cnt == LAT_W'(MEM_RD_LATENCY - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            oc          <= '0;
            tile        <= '0;
            ic          <= '0;
            drain_cnt   <= '0;
            img_rd_addr <= '0;
            ker_rd_addr <= '0;
        end else begin
            state       <= state_next;
            oc          <= oc_n;
            tile        <= tile_n;
            ic          <= ic_n;
            drain_cnt   <= (state == DRAIN) ? drain_cnt + LAT_W'(1) : '0;
            img_rd_addr <= IW'(tile_n) * IW'(NUM_IN_CH) + IW'(ic_n);
            ker_rd_addr <= KW'(oc_n) * KW'(NUM_IN_CH) + KW'(ic_n);
        end
    end

    always_comb begin
        tag_in = '0;
        if (fire) begin
            tag_in.valid = 1'b1;
            tag_in.first = (ic == '0);
            tag_in.last  = ic_wrap;
            tag_in.oc    = TAG_IDX_W'(oc);
            tag_in.tile  = TAG_IDX_W'(tile);
        end
    end

    fft_sched_tag_pipe #(
        .DEPTH(MEM_RD_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mac_valid  = tag_out.valid;
    assign mac_first  = tag_out.first;
    assign mac_last   = tag_out.last;
    assign out_ch     = tag_out.oc[OC_W-1:0];
    assign out_tile   = tag_out.tile[T_W-1:0];
    assign unused_tag = ^{tag_out.oc, tag_out.tile};

endmodule

// File: tb/tb_fft_conv_tile_scheduler.sv
// Bench: two scheduler configurations checked against an issue/beat model every cycle.
module tb_fft_conv_tile_scheduler;

    localparam int ND = 2;

    logic       clk = 1'b0;
    logic       rst   [ND];
    logic       start [ND];
    logic       stall [ND];
    logic       busy  [ND];
    logic       done  [ND];
    logic       mv    [ND];
    logic       mf    [ND];
    logic       ml    [ND];
    logic [0:0] och   [ND];
    logic [0:0] otl   [ND];
    logic [12:0] img  [ND];
    logic [8:0]  ker  [ND];

    always #5 clk = ~clk;

    fft_conv_tile_scheduler #(
        .NUM_TILES(2), .NUM_IN_CH(3), .NUM_OUT_CH(2),
        .IMAGE_MEM_DEPTH_BITS(13), .KERNEL_MEM_DEPTH_BITS(9),
        .MEM_RD_LATENCY(1)
    ) u0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .stall(stall[0]),
        .busy(busy[0]), .done(done[0]),
        .img_rd_addr(img[0]), .ker_rd_addr(ker[0]),
        .mac_valid(mv[0]), .mac_first(mf[0]), .mac_last(ml[0]),
        .out_ch(och[0]), .out_tile(otl[0])
    );

    fft_conv_tile_scheduler #(
        .NUM_TILES(2), .NUM_IN_CH(1), .NUM_OUT_CH(2),
        .IMAGE_MEM_DEPTH_BITS(13), .KERNEL_MEM_DEPTH_BITS(9),
        .MEM_RD_LATENCY(3)
    ) u1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .stall(stall[1]),
        .busy(busy[1]), .done(done[1]),
        .img_rd_addr(img[1]), .ker_rd_addr(ker[1]),
        .mac_valid(mv[1]), .mac_first(mf[1]), .mac_last(ml[1]),
        .out_ch(och[1]), .out_tile(otl[1])
    );

    function automatic int p_t(input int d);   return 2; endfunction
    function automatic int p_ic(input int d);  return (d == 0) ? 3 : 1; endfunction
    function automatic int p_oc(input int d);  return 2; endfunction
    function automatic int p_lat(input int d); return (d == 0) ? 1 : 3; endfunction
    function automatic int total(input int d); return p_t(d) * p_ic(d) * p_oc(d); endfunction

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0d expected %0d cycle %0d", nm, d, act, exp, cyc);
        end
    endtask

    // model: phase 0 idle, 1 issuing, 2 waiting for the final beats and done
    int phase   [ND];
    int nxt     [ND];
    int bptr    [ND];
    int done_at [ND];
    int icyc    [ND][64];
    int v, idx, e_ic, e_tl, e_oc;

    initial begin
        for (int d = 0; d < ND; d++) begin
            phase[d] = 0; nxt[d] = 0; bptr[d] = 0; done_at[d] = -1;
        end
    end

    always begin
        @(posedge clk);
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (rst[d]) begin
                case (phase[d])
                    0: if (start[d]) begin
                        phase[d] = 1; nxt[d] = 0; bptr[d] = 0;
                    end
                    1: if (!stall[d]) begin
                        icyc[d][nxt[d]] = cyc - 1;
                        nxt[d]++;
                        if (nxt[d] == total(d)) begin
                            phase[d] = 2;
                            done_at[d] = cyc - 1 + p_lat(d) + 1;
                        end
                    end
                    default: if (cyc - 1 == done_at[d]) phase[d] = 0;
                endcase
            end
        end
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (!rst[d]) begin
                phase[d] = 0; nxt[d] = 0; bptr[d] = 0;
                chk("rst_busy", d, busy[d], 0);
                chk("rst_done", d, done[d], 0);
                chk("rst_valid", d, mv[d], 0);
                chk("rst_first", d, mf[d], 0);
                chk("rst_last", d, ml[d], 0);
                chk("rst_img", d, img[d], 0);
                chk("rst_ker", d, ker[d], 0);
            end else begin
                v = 0; idx = 0;
                if (bptr[d] < nxt[d] && icyc[d][bptr[d]] + p_lat(d) == cyc) begin
                    v = 1; idx = bptr[d]; bptr[d]++;
                end
                e_ic = idx % p_ic(d);
                e_tl = (idx / p_ic(d)) % p_t(d);
                e_oc = idx / (p_ic(d) * p_t(d));
                chk("busy", d, busy[d], phase[d] != 0);
                chk("done", d, done[d], phase[d] == 2 && cyc == done_at[d]);
                chk("mac_valid", d, mv[d], v);
                chk("mac_first", d, mf[d], v == 1 && e_ic == 0);
                chk("mac_last", d, ml[d], v == 1 && e_ic == p_ic(d) - 1);
                chk("out_ch", d, och[d], v ? e_oc : 0);
                chk("out_tile", d, otl[d], v ? e_tl : 0);
                if (phase[d] == 1) begin
                    e_ic = nxt[d] % p_ic(d);
                    e_tl = (nxt[d] / p_ic(d)) % p_t(d);
                    e_oc = nxt[d] / (p_ic(d) * p_t(d));
                    chk("img_addr", d, img[d], e_tl * p_ic(d) + e_ic);
                    chk("ker_addr", d, ker[d], e_oc * p_ic(d) + e_ic);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done[d]) begin
                n = i;
                break;
            end
        end
    endtask

    int img_l   [12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
    int ker_l   [12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    int first_l [12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int last_l  [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int oc_l    [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int tile_l  [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int img1_l  [4]  = '{0, 1, 0, 1};
    int ker1_l  [4]  = '{0, 0, 1, 1};
    int n;

    initial begin
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b0; start[d] = 1'b0; stall[d] = 1'b0;
        end
        @(negedge clk);
        chk("lit_reset_busy", 0, busy[0], 0);
        chk("lit_reset_valid", 1, mv[1], 0);
        repeat (2) tick;
        rst[0] = 1'b1; rst[1] = 1'b1;
        repeat (2) tick;

        // plain run: addresses, beat flags, tags and done timing
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (j <= 12) begin
                chk("lit_img", 0, img[0], img_l[j-1]);
                chk("lit_ker", 0, ker[0], ker_l[j-1]);
            end
            chk("lit_valid", 0, mv[0], j >= 2 && j <= 13);
            if (j >= 2 && j <= 13) begin
                chk("lit_first", 0, mf[0], first_l[j-2]);
                chk("lit_last", 0, ml[0], last_l[j-2]);
                chk("lit_out_ch", 0, och[0], oc_l[j-2]);
                chk("lit_out_tile", 0, otl[0], tile_l[j-2]);
            end
            chk("lit_done", 0, done[0], j == 14);
        end
        tick;

        // three stall cycles after issue 5, with a stray start while running
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        repeat (5) tick;
        stall[0] = 1'b1; start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        tick;
        tick;
        stall[0] = 1'b0;
        wait_done(0, 40, n);
        chk("lit_stall_done_lat", 0, n, 9);

        // restart in the idle cycle right after done
        tick;
        start[0] = 1'b1;
        @(negedge clk);
        chk("lit_idle_after_done", 0, busy[0], 0);
        tick;
        start[0] = 1'b0;
        wait_done(0, 40, n);
        chk("lit_restart_done_lat", 0, n, 14);

        // abort at issue 7, then a fresh full run
        tick;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        repeat (6) tick;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("lit_abort_busy", 0, busy[0], 0);
        chk("lit_abort_valid", 0, mv[0], 0);
        tick;
        rst[0] = 1'b1;
        tick;
        start[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        wait_done(0, 40, n);
        chk("lit_after_abort_done_lat", 0, n, 14);
        tick;

        // latency 3, one input channel
        start[1] = 1'b1;
        tick;
        start[1] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j <= 4) begin
                chk("lit1_img", 1, img[1], img1_l[j-1]);
                chk("lit1_ker", 1, ker[1], ker1_l[j-1]);
            end
            chk("lit1_valid", 1, mv[1], j >= 4 && j <= 7);
            if (j >= 4 && j <= 7) begin
                chk("lit1_first", 1, mf[1], 1);
                chk("lit1_last", 1, ml[1], 1);
                chk("lit1_out_ch", 1, och[1], ker1_l[j-4]);
                chk("lit1_out_tile", 1, otl[1], img1_l[j-4]);
            end
            chk("lit1_done", 1, done[1], j == 8);
        end
        tick;

        for (int i = 0; i < 3000; i++) begin
            tick;
            for (int d = 0; d < ND; d++) begin
                rst[d]   = ($urandom_range(0, 249) != 0);
                start[d] = ($urandom_range(0, 7) == 0);
                stall[d] = ($urandom_range(0, 3) == 0);
            end
        end
        tick;
        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; stall[d] = 1'b0;
        end
        repeat (40) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
